// File: rtl/lvt_multiport_ram.sv
// Multi-ported RAM: N_WR x N_RD simple dual-port banks steered by a Live Value Table,
// with a power-up clear sweep, highest-port-wins write collisions and read-valid pulses.
module lvt_multiport_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int N_WR       = 2,
  parameter int N_RD       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         ready,
  input  logic [N_WR-1:0]              wren,
  input  logic [N_WR*ADDR_WIDTH-1:0]   wrAddr,
  input  logic [N_WR*DATA_WIDTH-1:0]   dIn,
  input  logic [N_RD-1:0]              rden,
  input  logic [N_RD*ADDR_WIDTH-1:0]   rdAddr,
  output logic [N_RD*DATA_WIDTH-1:0]   dOut,
  output logic [N_RD-1:0]              rdValid,
  output logic                         wrCollision
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LVT_W = (N_WR > 1) ? $clog2(N_WR) : 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    ready_q;
  logic [N_RD-1:0]         rd_valid_q;
  logic                    wr_coll_q;
  logic [DATA_WIDTH-1:0]   dout_q [N_RD];
  logic [DATA_WIDTH-1:0]   mem_q  [N_WR][N_RD][DEPTH];
  logic [LVT_W-1:0]        lvt_q  [DEPTH];
  logic [N_WR-1:0]         we_s;
  logic                    coll_s;

  // A write port loses whenever any higher-numbered enabled port targets the same address.
  always_comb begin
    we_s   = {N_WR{1'b0}};
    coll_s = 1'b0;
    for (int w = 0; w < N_WR; w++) begin
      if ((state_q == ST_RUN) && wren[w]) begin
        we_s[w] = 1'b1;
        for (int j = w + 1; j < N_WR; j++) begin
          if (wren[j] && (wrAddr[j*ADDR_WIDTH +: ADDR_WIDTH] == wrAddr[w*ADDR_WIDTH +: ADDR_WIDTH])) begin
            we_s[w] = 1'b0;
            coll_s  = 1'b1;
          end else begin
            coll_s  = coll_s;
          end
        end
      end else begin
        we_s[w] = 1'b0;
      end
    end
  end

  // Control state machine plus registered read data and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      clr_addr_q <= {ADDR_WIDTH{1'b0}};
      ready_q    <= 1'b0;
      rd_valid_q <= {N_RD{1'b0}};
      wr_coll_q  <= 1'b0;
      for (int r = 0; r < N_RD; r++) dout_q[r] <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_addr_q <= clr_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          rd_valid_q <= {N_RD{1'b0}};
          wr_coll_q  <= 1'b0;
          if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          rd_valid_q <= rden;
          wr_coll_q  <= coll_s;
          // LVT and bank are sampled before this edge's writes land: read-before-write.
          for (int r = 0; r < N_RD; r++) begin
            if (rden[r]) begin
              dout_q[r] <= mem_q[lvt_q[rdAddr[r*ADDR_WIDTH +: ADDR_WIDTH]]][r][rdAddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            end
          end
        end
        default: begin
          state_q <= ST_INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Bank and LVT storage: cleared one address per cycle during INIT, written by winners in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == ST_INIT) begin
        for (int w = 0; w < N_WR; w++)
          for (int r = 0; r < N_RD; r++)
            mem_q[w][r][clr_addr_q] <= {DATA_WIDTH{1'b0}};
        lvt_q[clr_addr_q] <= {LVT_W{1'b0}};
      end else begin
        for (int w = 0; w < N_WR; w++) begin
          if (we_s[w]) begin
            for (int r = 0; r < N_RD; r++)
              mem_q[w][r][wrAddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= dIn[w*DATA_WIDTH +: DATA_WIDTH];
            lvt_q[wrAddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= LVT_W'(w);
          end
        end
      end
    end
  end

  // Flatten per-port read registers onto the packed output bus.
  always_comb begin
    dOut = {(N_RD*DATA_WIDTH){1'b0}};
    for (int r = 0; r < N_RD; r++) dOut[r*DATA_WIDTH +: DATA_WIDTH] = dout_q[r];
  end

  assign ready       = ready_q;
  assign rdValid     = rd_valid_q;
  assign wrCollision = wr_coll_q;
endmodule

// File: doc/lvt_multiport_ram.md
# lvt_multiport_ram

Parametrised multi-ported RAM with N_WR write ports and N_RD read ports, built from simple dual-port banks plus a Live Value Table (LVT). Each write port owns one bank group, replicated N_RD times, so every read port has a private copy. The LVT records which write port last wrote each address and steers each read port to that bank. It generalises the fixed 2W/2R LVT memory with these additions:
- arbitrary port counts;
- a power-up clear sequencer;
- deterministic write-collision resolution;
- read-valid signalling.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 5, address width; depth DEPTH = 2**ADDR_WIDTH
- N_WR, 2, number of write ports (1..8)
- N_RD, 2, number of read ports (1..8)
- clk  input  1  single clock, all logic rising-edge
- reset  input  1  synchronous, active-low reset
- ready  output  1  high when the clear sweep is done and accesses are accepted
- wren  input  N_WR  per-port write enable
- wrAddr  input  N_WR*ADDR_WIDTH  write addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- dIn  input  N_WR*DATA_WIDTH  write data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- rden  input  N_RD  per-port read enable
- rdAddr  input  N_RD*ADDR_WIDTH  read addresses, same packing as wrAddr
- dOut  output  N_RD*DATA_WIDTH  registered read data
- rdValid  output  N_RD  one-cycle pulse per port; dOut for that port is valid
- wrCollision  output  1  one-cycle pulse: two or more enabled write ports targeted the same address

## Operation
- **Storage:** N_WR x N_RD banks, each DEPTH x DATA_WIDTH.
  - Bank (w,r) is written only by write port w and read only by read port r.
  - Bank read is registered and read-before-write.
- **LVT:** DEPTH entries of LVT_W = max(1, clog2(N_WR)) bits each.
  - Flop-based, combinational read, written at the clock edge.
- **State machine:** two states, INIT and RUN.
  - reset=0 at an edge: state <= INIT, clrAddr <= 0, ready/rdValid/wrCollision <= 0, dOut <= 0.
  - INIT, reset=1: writes 0 to address clrAddr in every bank and in the LVT, then clrAddr++.
  - When clrAddr == DEPTH-1 is written: state <= RUN, ready <= 1.
  - RUN: stays in RUN until reset.
- **Accesses outside RUN:** while ready=0, wren and rden are ignored; rdValid stays 0 and wrCollision stays 0.
- **Write (RUN):** if enabled, write port w writes dIn[w] into banks (w,0..N_RD-1) at wrAddr[w], and sets LVT[wrAddr[w]] <= w.
- **Collision:** if several enabled write ports share one address, the highest-numbered port wins.
  - Only the winner's banks and the LVT entry are updated.
  - Losing ports write nothing.
  - wrCollision pulses high for one cycle after that edge.
  - Writes from non-colliding ports in the same cycle proceed normally.
- **Read (RUN):** with rden[r]=1 at edge t:
  - LVT[rdAddr[r]] is sampled before edge t's LVT update and registered as sel[r].
  - Bank (sel,r) is read at rdAddr[r].
  - dOut[r] presents bank (sel[r], r) output after edge t; rdValid[r]=1 for exactly that cycle.
- **Read-during-write to the same address at the same edge:** returns the old value, both the old LVT pointer and the old bank data.
- **Read hold:** with rden[r]=0, dOut[r] holds its last value and rdValid[r]=0.
- **Read-port independence:** multiple read ports may use identical addresses freely; no read/read conflict exists.

## Timing
- **Read latency:** 1 cycle from the rden edge to valid dOut/rdValid.
- **Write visibility:** data written at edge t is visible to a read issued at edge t+1 or later.
- **Throughput:** every port accepts a new access every cycle in RUN.
- **Init duration:** ready rises after exactly DEPTH rising edges with reset=1 (32 for defaults).
- **Reset mid-operation:** aborts everything, the sweep restarts from address 0, and stored data is treated as cleared once ready returns.
- **Output reset values:** ready=0, dOut=0, rdValid=0, wrCollision=0.

## Test plan
- **Init sweep:** hold reset=0 for 2 cycles, release.
  - ready=0 for 31 cycles, 1 at cycle 32.
  - Reading addresses 0..31 on all ports returns 0 with rdValid pulses.
- **Basic two-port write/read:** port0 writes 0xA5 @3 and port1 writes 0x5A @7.
  - Next cycle, rd0 @7 and rd1 @3 give dOut0=0x5A, dOut1=0xA5 one cycle later.
- **Collision:** port0 writes 0x11 @9 and port1 writes 0x22 @9 at the same edge.
  - wrCollision=1 for one cycle.
  - Subsequent reads @9 on all ports return 0x22.
- **Read-during-write:** address 4 holds 0x33; at one edge port0 writes 0x44 @4 while rd0 reads @4.
  - dOut0=0x33.
  - The read at the next edge returns 0x44.
- **Overwrite across ports:** port1 writes 0x77 @12, then port0 writes 0x88 @12.
  - All read ports return 0x88, proving the LVT steers to bank 0.
- **Reset mid-operation:** write 0xFF @1, pulse reset=0 for one edge while rden is active.
  - rdValid and ready drop to 0 next cycle.
  - After 32 cycles, read @1 returns 0x00.
